// File: rtl/viterbi_k3_pkg.sv
// Constants and types shared by the K=3 encoder, ACS and traceback blocks.
package viterbi_k3_pkg;

   localparam int unsigned K          = 3;
   localparam int unsigned NUM_STATES = 4;
   localparam int unsigned STATE_W    = K - 1;
   localparam int unsigned SYM_W      = 2;

   localparam logic [K-1:0] G0_DEFAULT = 3'b111;
   localparam logic [K-1:0] G1_DEFAULT = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TAIL = 2'd2
   } enc_fsm_e;

   // Payload held in the encoder output register.
   typedef struct packed {
      logic [SYM_W-1:0] code;
      logic             last;
   } sym_t;

endpackage

// File: rtl/conv_encoder_k3_if.sv
// Bit-in / symbol-out handshake bundle of the K=3 convolutional encoder.
interface conv_encoder_k3_if;

   logic                               in_bit;
   logic                               in_valid;
   logic                               in_ready;
   logic [viterbi_k3_pkg::SYM_W-1:0]   code_out;
   logic                               out_valid;
   logic                               out_ready;
   logic                               out_last;

   // slave: the encoder; master: the source/sink surrounding it
   modport slave (
      input  in_bit, in_valid, out_ready,
      output in_ready, code_out, out_valid, out_last
   );

   modport master (
      output in_bit, in_valid, out_ready,
      input  in_ready, code_out, out_valid, out_last
   );

endinterface

// File: rtl/conv_enc_unit.sv
// One trellis step forward: parity pair and successor state for a given bit.
module conv_enc_unit
   import viterbi_k3_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEFAULT,
   parameter logic [K-1:0] G1 = G1_DEFAULT
) (
   input  logic [STATE_W-1:0] state,
   input  logic               enc_bit,
   output logic [STATE_W-1:0] next_state,
   output logic [SYM_W-1:0]   code
);

   logic [K-1:0] taps;

   assign taps       = {enc_bit, state};
   assign next_state = {enc_bit, state[STATE_W-1]};
   assign code       = {^(taps & G0), ^(taps & G1)};

endmodule

// File: rtl/conv_encoder_k3.sv
// Framed rate-1/2 K=3 convolutional encoder with optional zero-tail termination.
module conv_encoder_k3
   import viterbi_k3_pkg::*;
#(
   parameter int unsigned  LEN_W   = 8,
   parameter logic [K-1:0] G0      = G0_DEFAULT,
   parameter logic [K-1:0] G1      = G1_DEFAULT,
   parameter bit           TAIL_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [LEN_W-1:0]   frame_len,
   conv_encoder_k3_if.slave   bus,
   output logic [STATE_W-1:0] enc_state,
   output logic               busy
);

   enc_fsm_e             state_q, state_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic                 tail_idx_q, tail_idx_d;
   logic [STATE_W-1:0]   enc_q, enc_d;
   sym_t                 sym_q, sym_d;
   logic                 out_valid_q, out_valid_d;

   logic                 can_load_c;
   logic                 in_ready_c;
   logic                 enc_bit_c;
   logic [STATE_W-1:0]   enc_next_c;
   logic [SYM_W-1:0]     code_c;

   // Output register is free when empty or being drained this cycle.
   assign can_load_c = !out_valid_q || bus.out_ready;
   assign enc_bit_c  = (state_q == ST_DATA) ? bus.in_bit : 1'b0;

   conv_enc_unit #(
      .G0 (G0),
      .G1 (G1)
   ) u_enc_unit (
      .state      (enc_q),
      .enc_bit    (enc_bit_c),
      .next_state (enc_next_c),
      .code       (code_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         tail_idx_q  <= 1'b0;
         enc_q       <= '0;
         sym_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tail_idx_q  <= tail_idx_d;
         enc_q       <= enc_d;
         sym_q       <= sym_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tail_idx_d  = tail_idx_q;
      enc_d       = enc_q;
      sym_d       = sym_q;
      out_valid_d = out_valid_q;
      in_ready_c  = 1'b0;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && (frame_len != '0)) begin
               cnt_d      = frame_len;
               enc_d      = '0;
               tail_idx_d = 1'b0;
               state_d    = ST_DATA;
            end
         end

         ST_DATA: begin
            in_ready_c = can_load_c;
            if (bus.in_valid && can_load_c) begin
               sym_d.code  = code_c;
               sym_d.last  = 1'b0;
               out_valid_d = 1'b1;
               enc_d       = enc_next_c;
               cnt_d       = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  if (TAIL_EN) begin
                     tail_idx_d = 1'b0;
                     state_d    = ST_TAIL;
                  end else begin
                     sym_d.last = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end
            end
         end

         ST_TAIL: begin
            // Two zero bits flush the register back to state 00.
            if (can_load_c) begin
               sym_d.code  = code_c;
               sym_d.last  = tail_idx_q;
               out_valid_d = 1'b1;
               enc_d       = enc_next_c;
               if (tail_idx_q) begin
                  state_d = ST_IDLE;
               end else begin
                  tail_idx_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.code_out  = sym_q.code;
   assign bus.out_last  = sym_q.last;
   assign bus.out_valid = out_valid_q;
   assign enc_state     = enc_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: directed + random frames against a polynomial model and a Viterbi decoder.
module tb_conv_encoder_k3;
   import viterbi_k3_pkg::*;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned MAX_SYM = 300;

   typedef struct packed {
      logic [1:0] code;
      logic       last;
      logic [1:0] st;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [LEN_W-1:0] frame_len;
   logic             in_bit;
   logic             in_valid;
   logic             out_ready;
   logic [1:0]       enc_state1, enc_state0;
   logic             busy1, busy0;

   int   checks = 0;
   int   errors = 0;
   logic src_q[$];
   rec_t got1[$];
   rec_t got0[$];
   rec_t exp_q[$];

   conv_encoder_k3_if bus1();
   conv_encoder_k3_if bus0();

   assign bus1.in_bit    = in_bit;
   assign bus1.in_valid  = in_valid;
   assign bus1.out_ready = out_ready;
   assign bus0.in_bit    = in_bit;
   assign bus0.in_valid  = in_valid;
   assign bus0.out_ready = out_ready;

   always #5 clk = ~clk;

   conv_encoder_k3 #(.LEN_W(LEN_W), .TAIL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .bus       (bus1),
      .enc_state (enc_state1),
      .busy      (busy1)
   );

   conv_encoder_k3 #(.LEN_W(LEN_W), .TAIL_EN(1'b0)) dut_notail (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .bus       (bus0),
      .enc_state (enc_state0),
      .busy      (busy0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected symbols straight from the generator polynomials 1+D+D^2 and 1+D^2.
   task automatic build_exp(input int len, input bit tail);
      int   n, b, d1, d2;
      rec_t r;
      n  = len + (tail ? 2 : 0);
      d1 = 0;
      d2 = 0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         b      = (i < len) ? int'(src_q[i]) : 0;
         r.code = {1'(b ^ d1 ^ d2), 1'(b ^ d2)};
         r.st   = {1'(b), 1'(d1)};
         r.last = 1'(i == n - 1);
         exp_q.push_back(r);
         d2 = d1;
         d1 = b;
      end
   endtask

   task automatic check_frame(input string tag, input int len, input bit tail);
      rec_t g[$];
      rec_t r;
      build_exp(len, tail);
      if (tail) g = got1;
      else      g = got0;
      chk({tag, "_count"}, 32'(g.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         r = (i < g.size()) ? g[i] : '0;
         chk($sformatf("%s_sym%0d", tag, i), 32'(r), 32'(exp_q[i]));
      end
   endtask

   // Hard-decision Viterbi over the captured tailed frame; returns bit errors.
   function automatic int viterbi_errs(input int len);
      int pm[4];
      int npm[4];
      bit surv[MAX_SYM][4];
      int n, s, m, best, bx, errs, b, s1, c1, c0;
      bit dec[MAX_SYM];
      n    = got1.size();
      errs = 0;
      pm   = '{0, 1000, 1000, 1000};
      for (int t = 0; t < n; t++) begin
         for (int ns = 0; ns < 4; ns++) begin
            b    = ns / 2;
            s1   = ns % 2;
            best = 100000;
            bx   = 0;
            for (int x = 0; x < 2; x++) begin
               s  = s1 * 2 + x;
               c1 = b ^ s1 ^ x;
               c0 = b ^ x;
               m  = pm[s] + int'(c1 != int'(got1[t].code[1])) + int'(c0 != int'(got1[t].code[0]));
               if (m < best) begin
                  best = m;
                  bx   = x;
               end
            end
            npm[ns]      = best;
            surv[t][ns]  = 1'(bx);
         end
         pm = npm;
      end
      s = 0;
      for (int t = n - 1; t >= 0; t--) begin
         dec[t] = 1'(s / 2);
         s      = (s % 2) * 2 + int'(surv[t][s]);
      end
      for (int i = 0; i < len; i++) begin
         if (dec[i] != src_q[i]) errs++;
      end
      if (pm[0] != 0) errs++;
      return errs;
   endfunction

   // Called at a negedge; returns at a negedge once the tailed frame's last symbol is taken.
   task automatic run_frame(input int len, input int bp, input bit mid_start, input int abort_after);
      int         acc;
      bit         done;
      bit         prev_stall;
      logic [1:0] prev_code;
      rec_t       r;
      acc        = 0;
      done       = 1'b0;
      prev_stall = 1'b0;
      prev_code  = 2'b00;
      got1.delete();
      got0.delete();
      start     = 1'b1;
      frame_len = LEN_W'(len);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy1), 32'd1);
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (prev_stall) begin
            chk("hold_valid", 32'(bus1.out_valid), 32'd1);
            chk("hold_code", 32'(bus1.code_out), 32'(prev_code));
         end
         case (bp)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(1));
         endcase
         in_valid = (acc < len) && ($urandom_range(3) != 0);
         in_bit   = (acc < len) ? src_q[acc] : 1'($urandom);
         start    = mid_start && (cyc == 3);
         if (mid_start) frame_len = LEN_W'(3);
         #1;
         if (bus1.out_valid && !out_ready) begin
            chk("stall_in_ready", 32'(bus1.in_ready), 32'd0);
         end
         prev_stall = bus1.out_valid && !out_ready;
         prev_code  = bus1.code_out;
         if (bus1.out_valid && out_ready) begin
            r.code = bus1.code_out;
            r.last = bus1.out_last;
            r.st   = enc_state1;
            got1.push_back(r);
            done = bus1.out_last;
         end
         if (bus0.out_valid && out_ready) begin
            r.code = bus0.code_out;
            r.last = bus0.out_last;
            r.st   = enc_state0;
            got0.push_back(r);
         end
         if (in_valid && bus1.in_ready) acc++;
         @(negedge clk);
         start = 1'b0;
         if (abort_after > 0 && acc == abort_after) begin
            rst_n    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk("abort_out_valid", 32'(bus1.out_valid), 32'd0);
            chk("abort_enc_state", 32'(enc_state1), 32'd0);
            chk("abort_busy", 32'(busy1), 32'd0);
            rst_n = 1'b1;
            return;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("frame_done", 32'(done), 32'd1);
   endtask

   task automatic load_basic();
      src_q.delete();
      src_q.push_back(1'b1);
      src_q.push_back(1'b0);
      src_q.push_back(1'b1);
      src_q.push_back(1'b1);
   endtask

   initial begin
      int spec_code[6];
      int spec_st[6];
      int total;
      int len;
      rec_t r;

      spec_code = '{3, 2, 0, 1, 1, 3};
      spec_st   = '{2, 1, 2, 3, 1, 0};

      // Reset held for two edges with garbage on the inputs
      rst_n = 1'b0;
      repeat (2) begin
         start     = 1'($urandom);
         frame_len = LEN_W'($urandom);
         in_bit    = 1'($urandom);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
      end
      chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
      chk("rst_code_out", 32'(bus1.code_out), 32'd0);
      chk("rst_out_last", 32'(bus1.out_last), 32'd0);
      chk("rst_in_ready", 32'(bus1.in_ready), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_enc_state", 32'(enc_state1), 32'd0);
      rst_n = 1'b1;

      // Basic frame, no backpressure, start straight after reset release
      load_basic();
      run_frame(4, 0, 1'b0, 0);
      check_frame("basic", 4, 1'b1);
      check_frame("basic_notail", 4, 1'b0);
      for (int i = 0; i < 6; i++) begin
         r = (i < got1.size()) ? got1[i] : '0;
         chk($sformatf("basic_table_code%0d", i), 32'(r.code), 32'(spec_code[i]));
         chk($sformatf("basic_table_st%0d", i), 32'(r.st), 32'(spec_st[i]));
      end
      chk("basic_busy_end", 32'(busy1), 32'd0);

      // Same frame under 1,0,0 backpressure
      load_basic();
      run_frame(4, 1, 1'b0, 0);
      check_frame("bp", 4, 1'b1);
      check_frame("bp_notail", 4, 1'b0);

      // Single-bit frame
      src_q.delete();
      src_q.push_back(1'b1);
      run_frame(1, 0, 1'b0, 0);
      check_frame("len1", 1, 1'b1);

      // Zero-length start is ignored
      start     = 1'b1;
      frame_len = '0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("len0_busy", 32'(busy1), 32'd0);
      chk("len0_out_valid", 32'(bus1.out_valid), 32'd0);
      chk("len0_in_ready", 32'(bus1.in_ready), 32'd0);

      // Start pulsed mid-frame is ignored
      src_q.delete();
      repeat (8) src_q.push_back(1'($urandom));
      run_frame(8, 2, 1'b1, 0);
      check_frame("midstart", 8, 1'b1);
      chk("midstart_busy_end", 32'(busy1), 32'd0);

      // Reset after the second accepted bit, then a clean frame
      load_basic();
      run_frame(4, 0, 1'b0, 2);
      load_basic();
      run_frame(4, 0, 1'b0, 0);
      check_frame("post_abort", 4, 1'b1);

      // Random frames, random backpressure, decoded back through Viterbi
      total = 0;
      while (total < 200) begin
         len = int'($urandom_range(20, 1));
         if (len > 200 - total) len = 200 - total;
         src_q.delete();
         repeat (len) src_q.push_back(1'($urandom));
         run_frame(len, 2, 1'b0, 0);
         check_frame("loop", len, 1'b1);
         check_frame("loop_notail", len, 1'b0);
         chk("loop_decode_errs", 32'(viterbi_errs(len)), 32'd0);
         r = (got1.size() > 0) ? got1[got1.size() - 1] : '1;
         chk("loop_end_state", 32'(r.st), 32'd0);
         total += len;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
Framed rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the K=3 Viterbi traceback decoder. It consumes one information bit per handshake and emits one 2-bit code symbol per bit. After the last data bit it appends K-1 = 2 zero tail bits, so every frame terminates in state 00, which is the state the decoder's traceback starts from.

Parameters:
LEN_W, 8, width of frame_len and of the internal bit counter; frames of 1..2^LEN_W-1 bits.
G0, 3'b111, generator polynomial for code_out[1]; bit 2 taps the input bit, bit 1 taps state[1], bit 0 taps state[0].
G1, 3'b101, generator polynomial for code_out[0]; same tap ordering as G0.
TAIL_EN, 1, 1 = append 2 zero tail symbols per frame; 0 = no tail, and the frame ends on the last data symbol.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  frame-start pulse; sampled only in IDLE.
frame_len  in  LEN_W  number of data bits in the frame; sampled together with start.
in_bit  in  1  information bit.
in_valid  in  1  in_bit is valid.
in_ready  out  1  encoder accepts in_bit this cycle.
code_out  out  2  code symbol; [1] = G0 parity, [0] = G1 parity.
out_valid  out  1  code_out is valid.
out_ready  in  1  downstream accepts code_out.
out_last  out  1  qualifies the final symbol of the frame; meaningful only while out_valid = 1.
enc_state  out  2  current shift-register state; the newest bit is the MSB.
busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces: FSM = IDLE, enc_state = 00, counter = 0, code_out = 00, out_valid = 0, out_last = 0, in_ready = 0, busy = 0.
- Reset asserted mid-frame aborts the frame. Any pending output symbol is dropped and not replayed.
- State update on each encoded bit b: next enc_state = {b, enc_state[1]}.
  - Consequently the previous state equals {enc_state[0], survivor bit}, and the decoded bit equals enc_state[1]. This matches the decoder's traceback convention.
- Parity computation, with tap vector v = {b, enc_state[1], enc_state[0]}:
  - code_out[1] = XOR-reduce(v & G0)
  - code_out[0] = XOR-reduce(v & G1)
- Output stage is a single register. It may load when out_valid = 0, or when out_valid = 1 and out_ready = 1 in the same cycle. Define can_load as that condition.
- out_valid, code_out and out_last hold stable while out_valid = 1 and out_ready = 0.
- FSM states:
  - IDLE: in_ready = 0. If start = 1 and frame_len != 0: latch counter = frame_len, set enc_state = 00, go to DATA. start with frame_len = 0 is ignored and the FSM stays in IDLE.
  - DATA: in_ready = can_load. An accept (in_valid & in_ready) encodes in_bit, loads the output register, updates enc_state and decrements the counter. When the accept happens with counter = 1:
    - TAIL_EN = 1: go to TAIL with the tail index set to 0.
    - TAIL_EN = 0: set out_last = 1 on this symbol and go to IDLE.
  - TAIL: in_ready = 0. On each can_load, encode b = 0 and load the output register. The second tail symbol (tail index 1) carries out_last = 1, and the FSM then goes to IDLE.
- start while busy = 1 is ignored.
- A new start is accepted in IDLE even while the final symbol is still pending in the output register. Back-to-back frames therefore need no bubble beyond the IDLE cycle.
- Latency: a symbol is visible on out_valid in the cycle after its input is accepted.
- Throughput: 1 symbol per clock when out_ready is held at 1.
- Frame length on the wire is frame_len + 2 symbols when TAIL_EN = 1, and frame_len symbols when TAIL_EN = 0.

Decomposition:
- Package viterbi_k3_pkg holds:
  - K = 3, NUM_STATES = 4
  - default G0 = 3'b111 and G1 = 3'b101
  - FSM state encoding IDLE / DATA / TAIL
  These constants are shared with the ACS and traceback blocks.
- One combinational sub-module, conv_enc_unit (inputs: state, bit; outputs: next_state, code). It is the forward counterpart of the traceback unit cell and is reused by the bench reference model.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with random inputs -> all outputs 0 and enc_state = 00; start on the first cycle after release -> busy = 1 on the next cycle.
- Basic frame, out_ready = 1: frame_len = 4, bits 1,0,1,1 -> code_out sequence 11,10,00,01,01,11; enc_state sequence 10,01,10,11,01,00; out_last only on the 6th symbol; busy low afterwards.
- Backpressure: same frame with out_ready toggling 1,0,0,1,... -> in_ready = 0 whenever out_valid = 1 and out_ready = 0; code_out held stable; output sequence identical; no bit lost or duplicated.
- Boundaries:
  - frame_len = 1 with bit 1 -> symbols 11,10,11, out_last on the 3rd.
  - frame_len = 0 -> no activity.
  - start pulsed mid-frame -> ignored.
  - TAIL_EN = 0, bits 1,0,1,1 -> 11,10,00,01 with out_last on the 4th.
- Reset mid-frame: assert rst_n = 0 after the 2nd accepted bit -> out_valid = 0 and enc_state = 00 next cycle; a following frame_len = 4 frame of 1,0,1,1 reproduces the basic-frame sequence exactly.
- Loopback: 200 random bits in frames of random length, encoded then fed through the traceback decoder -> decoded bits equal the source bits, and each frame ends in state 00.
